// File: rtl/regfile_sequencer.sv
// Operand-fetch / write-back controller driving the Argon register-file command bus.
// Latches indices, reads A and B, hands them to the ALU, then writes the result to rC and optionally F.
package regfile_pkg;
    localparam logic [3:0] COM_NOP      = 4'h0;
    localparam logic [3:0] COM_LATCHSEL = 4'h1;
    localparam logic [3:0] COM_READA    = 4'h2;
    localparam logic [3:0] COM_READB    = 4'h3;
    localparam logic [3:0] COM_LATCHC   = 4'h4;
    localparam logic [3:0] COM_LATCHF   = 4'h5;
endpackage

// state | meaning
// IDLE  | ready for an instruction        SEL  | latch rA/rB/rC selection   RDA | read operand A
// RDB   | read operand B                  EXEC | offer operands to ALU      WAIT| await ALU result / timeout
// WB    | write result to rC              FLG  | write flags to F           DONE| retire pulse
module regfile_sequencer
    import regfile_pkg::*;
#(
    parameter int WORD_WIDTH  = 16,
    parameter int INDEX_WIDTH = 3,
    parameter int CMD_WIDTH   = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic                   i_Clk,
    input  logic                   i_Reset_n,
    input  logic                   i_Instr_Valid,
    output logic                   o_Instr_Ready,
    input  logic [INDEX_WIDTH-1:0] i_IdxA,
    input  logic [INDEX_WIDTH-1:0] i_IdxB,
    input  logic [INDEX_WIDTH-1:0] i_IdxC,
    input  logic [3:0]             i_AluOp,
    input  logic                   i_SetFlags,
    output logic                   o_Rf_Valid,
    output logic [CMD_WIDTH-1:0]   o_Rf_Command,
    output logic [WORD_WIDTH-1:0]  o_Rf_Data,
    input  logic [WORD_WIDTH-1:0]  i_Rf_Data,
    input  logic                   i_Rf_Valid,
    output logic                   o_Alu_Valid,
    input  logic                   i_Alu_Ready,
    output logic [3:0]             o_Alu_Op,
    output logic [WORD_WIDTH-1:0]  o_Alu_A,
    output logic [WORD_WIDTH-1:0]  o_Alu_B,
    input  logic                   i_Alu_Res_Valid,
    input  logic [WORD_WIDTH-1:0]  i_Alu_Result,
    input  logic [7:0]             i_Alu_Flags,
    output logic                   o_Done,
    output logic                   o_Error,
    output logic                   o_Busy
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_SEL, ST_RDA, ST_RDB, ST_EXEC, ST_WAIT, ST_WB, ST_FLG, ST_DONE
    } state_t;

    state_t                 r_state, w_next;
    logic [INDEX_WIDTH-1:0] r_idx_a, r_idx_b, r_idx_c;
    logic                   r_set_flags;
    logic [3:0]             r_alu_op;
    logic [WORD_WIDTH-1:0]  r_op_a, r_op_b, r_result;
    logic [7:0]             r_flags;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_error;
    logic                   w_accept, w_timeout;
    logic                   w_rf_valid, w_alu_valid;
    logic [CMD_WIDTH-1:0]   w_rf_cmd;
    logic [WORD_WIDTH-1:0]  w_rf_data;

    assign w_accept  = (r_state == ST_IDLE) && i_Instr_Valid;
    // Down-counter reaches zero on the TIMEOUT-th WAIT cycle.
    assign w_timeout = (r_cnt == '0);

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) r_state <= ST_IDLE;
        else            r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_rf_valid  = 1'b0;
        w_rf_cmd    = CMD_WIDTH'(COM_NOP);
        w_rf_data   = '0;
        w_alu_valid = 1'b0;
        case (r_state)
            ST_IDLE: if (i_Instr_Valid) w_next = ST_SEL;
            ST_SEL: begin
                w_rf_valid = 1'b1;
                w_rf_cmd   = CMD_WIDTH'(COM_LATCHSEL);
                w_rf_data  = WORD_WIDTH'({r_idx_c, r_idx_b, r_idx_a});
                w_next     = ST_RDA;
            end
            ST_RDA: begin
                w_rf_cmd = CMD_WIDTH'(COM_READA);
                w_next   = ST_RDB;
            end
            ST_RDB: begin
                w_rf_cmd = CMD_WIDTH'(COM_READB);
                w_next   = ST_EXEC;
            end
            ST_EXEC: begin
                w_alu_valid = 1'b1;
                if (i_Alu_Ready) w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (i_Alu_Res_Valid) w_next = ST_WB;
                else if (w_timeout)  w_next = ST_DONE;
            end
            ST_WB: begin
                w_rf_valid = 1'b1;
                w_rf_cmd   = CMD_WIDTH'(COM_LATCHC);
                w_rf_data  = r_result;
                w_next     = r_set_flags ? ST_FLG : ST_DONE;
            end
            ST_FLG: begin
                w_rf_valid = 1'b1;
                w_rf_cmd   = CMD_WIDTH'(COM_LATCHF);
                w_rf_data  = WORD_WIDTH'(r_flags);
                w_next     = ST_DONE;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_idx_a     <= '0;
            r_idx_b     <= '0;
            r_idx_c     <= '0;
            r_set_flags <= 1'b0;
            r_alu_op    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_cnt       <= '0;
            r_error     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_idx_a     <= i_IdxA;
                r_idx_b     <= i_IdxB;
                r_idx_c     <= i_IdxC;
                r_alu_op    <= i_AluOp;
                r_set_flags <= i_SetFlags;
            end
            case (r_state)
                ST_RDA: begin
                    r_op_a <= i_Rf_Valid ? i_Rf_Data : '0;
                    if (!i_Rf_Valid) r_error <= 1'b1;
                end
                ST_RDB: begin
                    r_op_b <= i_Rf_Valid ? i_Rf_Data : '0;
                    if (!i_Rf_Valid) r_error <= 1'b1;
                end
                ST_EXEC: r_cnt <= CNT_LOAD;
                ST_WAIT: begin
                    // A result on the terminal cycle still takes priority over the timeout.
                    if (i_Alu_Res_Valid) begin
                        r_result <= i_Alu_Result;
                        r_flags  <= i_Alu_Flags;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Ready is gated by reset so every output reads 0 while reset is held.
    assign o_Instr_Ready = (r_state == ST_IDLE) && i_Reset_n;
    assign o_Busy        = (r_state != ST_IDLE);
    assign o_Done        = (r_state == ST_DONE);
    assign o_Error       = r_error;
    assign o_Rf_Valid    = w_rf_valid;
    assign o_Rf_Command  = w_rf_cmd;
    assign o_Rf_Data     = w_rf_data;
    assign o_Alu_Valid   = w_alu_valid;
    assign o_Alu_Op      = r_alu_op;
    assign o_Alu_A       = r_op_a;
    assign o_Alu_B       = r_op_b;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: register-file and ALU responders plus an instruction-level reference model.
module tb_regfile_sequencer;
    import regfile_pkg::*;

    localparam int TO = 12;

    logic        i_Clk = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Instr_Valid = 1'b0;
    logic        o_Instr_Ready;
    logic [2:0]  i_IdxA = '0, i_IdxB = '0, i_IdxC = '0;
    logic [3:0]  i_AluOp = '0;
    logic        i_SetFlags = 1'b0;
    logic        o_Rf_Valid;
    logic [3:0]  o_Rf_Command;
    logic [15:0] o_Rf_Data;
    logic [15:0] i_Rf_Data = '0;
    logic        i_Rf_Valid = 1'b0;
    logic        o_Alu_Valid;
    logic        i_Alu_Ready = 1'b0;
    logic [3:0]  o_Alu_Op;
    logic [15:0] o_Alu_A, o_Alu_B;
    logic        i_Alu_Res_Valid = 1'b0;
    logic [15:0] i_Alu_Result = '0;
    logic [7:0]  i_Alu_Flags = '0;
    logic        o_Done, o_Error, o_Busy;

    always #5 i_Clk = ~i_Clk;

    regfile_sequencer #(
        .WORD_WIDTH(16), .INDEX_WIDTH(3), .CMD_WIDTH(4), .TIMEOUT(TO)
    ) dut (
        .i_Clk(i_Clk), .i_Reset_n(i_Reset_n),
        .i_Instr_Valid(i_Instr_Valid), .o_Instr_Ready(o_Instr_Ready),
        .i_IdxA(i_IdxA), .i_IdxB(i_IdxB), .i_IdxC(i_IdxC),
        .i_AluOp(i_AluOp), .i_SetFlags(i_SetFlags),
        .o_Rf_Valid(o_Rf_Valid), .o_Rf_Command(o_Rf_Command), .o_Rf_Data(o_Rf_Data),
        .i_Rf_Data(i_Rf_Data), .i_Rf_Valid(i_Rf_Valid),
        .o_Alu_Valid(o_Alu_Valid), .i_Alu_Ready(i_Alu_Ready), .o_Alu_Op(o_Alu_Op),
        .o_Alu_A(o_Alu_A), .o_Alu_B(o_Alu_B),
        .i_Alu_Res_Valid(i_Alu_Res_Valid), .i_Alu_Result(i_Alu_Result), .i_Alu_Flags(i_Alu_Flags),
        .o_Done(o_Done), .o_Error(o_Error), .o_Busy(o_Busy)
    );

    typedef struct packed {
        logic [2:0]        a, b, c;
        logic [3:0]        op;
        logic              sf, ok_a, ok_b, spur;
        logic signed [7:0] rdy_dly, res_dly;
        logic [7:0]        flags;
    } instr_t;

    typedef struct packed {
        instr_t      stim;
        logic [15:0] exp_sel, exp_a, exp_b, exp_res;
        logic        exp_wb;
        logic [7:0]  exp_done;
        logic        exp_err;
    } vec_t;

    int          n_chk = 0, n_err = 0;
    logic [15:0] rf_mem [8];
    logic [15:0] ref_mem[8];
    logic [7:0]  rf_f = '0, ref_f = '0;
    logic        ref_err = 1'b0;
    logic [2:0]  sel_a = '0, sel_b = '0, sel_c = '0;
    logic [3:0]  obs_cmd[$];
    logic [15:0] obs_data[$];
    int          obs_done;
    logic [15:0] obs_a, obs_b, obs_sel, obs_res;
    logic [3:0]  obs_op;
    logic        obs_wb;
    vec_t        vecs[6];
    instr_t      r;
    int          k;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a ^ b;
            default: return a | b;
        endcase
    endfunction

    function automatic vec_t mkv(input int a, b, c, op, sf, oka, okb, rdy, res, fl, spur,
                                 input int esel, ea, eb, eres, ewb, edone, eerr);
        vec_t v;
        v.stim.a = 3'(a);  v.stim.b = 3'(b);  v.stim.c = 3'(c);  v.stim.op = 4'(op);
        v.stim.sf = 1'(sf); v.stim.ok_a = 1'(oka); v.stim.ok_b = 1'(okb); v.stim.spur = 1'(spur);
        v.stim.rdy_dly = 8'(rdy); v.stim.res_dly = 8'(res); v.stim.flags = 8'(fl);
        v.exp_sel = 16'(esel); v.exp_a = 16'(ea); v.exp_b = 16'(eb); v.exp_res = 16'(eres);
        v.exp_wb = 1'(ewb); v.exp_done = 8'(edone); v.exp_err = 1'(eerr);
        return v;
    endfunction

    // One instruction end to end; the model predicts from the instruction alone, the responders react to the DUT.
    task automatic run(input instr_t t);
        logic [15:0] ea, eb, eres, esel, hold_a, hold_b;
        logic [3:0]  hold_op;
        logic        eto, stable, hs_seen, busy_done;
        int          rd, rs, edone, ncmd, exec_n, wait_k, n_hs;
        rd   = int'(t.rdy_dly);
        rs   = int'(t.res_dly);
        ea   = t.ok_a ? ref_mem[t.a] : 16'h0;
        eb   = t.ok_b ? ref_mem[t.b] : 16'h0;
        eres = alu_fn(t.op, ea, eb);
        esel = {7'h0, t.c, t.b, t.a};
        eto  = (rs < 0) || (rs > TO - 1);
        edone = eto ? 5 + rd + TO : 7 + rd + rs + int'(t.sf);
        ncmd  = eto ? 1 : (t.sf ? 3 : 2);
        ref_err = ref_err | ~t.ok_a | ~t.ok_b | eto;
        if (!eto && t.c != 3'd0) ref_mem[t.c] = eres;
        if (!eto && t.sf) ref_f = t.flags;

        obs_cmd.delete();
        obs_data.delete();
        chk("ready_idle", 32'(o_Instr_Ready), 32'd1);
        i_Instr_Valid = 1'b1;
        i_IdxA = t.a; i_IdxB = t.b; i_IdxC = t.c; i_AluOp = t.op; i_SetFlags = t.sf;
        @(negedge i_Clk);
        i_Instr_Valid = 1'b0;
        i_IdxA = 3'($urandom); i_IdxB = 3'($urandom); i_IdxC = 3'($urandom);
        i_AluOp = 4'($urandom); i_SetFlags = 1'($urandom);
        obs_done = -1; n_hs = 0; exec_n = 0; wait_k = 0;
        hs_seen = 1'b0; stable = 1'b1; busy_done = 1'b0;
        hold_a = '0; hold_b = '0; hold_op = '0;
        obs_a = '0; obs_b = '0; obs_op = '0;
        for (int cyc = 1; cyc <= 150 && obs_done < 0; cyc++) begin
            i_Rf_Valid = 1'b0; i_Rf_Data = 16'($urandom);
            i_Alu_Ready = 1'b0; i_Alu_Res_Valid = 1'b0;
            i_Alu_Result = 16'($urandom); i_Alu_Flags = 8'($urandom);
            if (o_Rf_Valid) begin
                obs_cmd.push_back(o_Rf_Command);
                obs_data.push_back(o_Rf_Data);
                if (o_Rf_Command == COM_LATCHSEL) {sel_c, sel_b, sel_a} = o_Rf_Data[8:0];
                else if (o_Rf_Command == COM_LATCHC && sel_c != 3'd0) rf_mem[sel_c] = o_Rf_Data;
                else if (o_Rf_Command == COM_LATCHF) rf_f = o_Rf_Data[7:0];
            end else if (o_Rf_Command == COM_READA) begin
                i_Rf_Valid = t.ok_a;
                if (t.ok_a) i_Rf_Data = rf_mem[sel_a];
            end else if (o_Rf_Command == COM_READB) begin
                i_Rf_Valid = t.ok_b;
                if (t.ok_b) i_Rf_Data = rf_mem[sel_b];
            end
            if (o_Alu_Valid) begin
                if (exec_n == 0) begin
                    hold_a = o_Alu_A; hold_b = o_Alu_B; hold_op = o_Alu_Op;
                end else if (o_Alu_A !== hold_a || o_Alu_B !== hold_b || o_Alu_Op !== hold_op) begin
                    stable = 1'b0;
                end
                if (exec_n >= rd) begin
                    i_Alu_Ready = 1'b1;
                    n_hs++;
                    hs_seen = 1'b1;
                    obs_a = o_Alu_A; obs_b = o_Alu_B; obs_op = o_Alu_Op;
                end else if (t.spur && exec_n == 0) begin
                    i_Alu_Res_Valid = 1'b1;
                end
                exec_n++;
            end else if (hs_seen) begin
                if (wait_k == rs) begin
                    i_Alu_Res_Valid = 1'b1;
                    i_Alu_Result = alu_fn(o_Alu_Op, o_Alu_A, o_Alu_B);
                    i_Alu_Flags = t.flags;
                end
                wait_k++;
            end
            if (o_Done) begin
                obs_done = cyc;
                busy_done = o_Busy;
            end
            @(negedge i_Clk);
        end
        i_Rf_Valid = 1'b0; i_Alu_Ready = 1'b0; i_Alu_Res_Valid = 1'b0;

        obs_sel = (obs_data.size() > 0) ? obs_data[0] : 16'hxxxx;
        obs_wb = 1'b0; obs_res = 16'hxxxx;
        foreach (obs_cmd[i]) if (obs_cmd[i] == COM_LATCHC) begin obs_wb = 1'b1; obs_res = obs_data[i]; end

        chk("done_latency", 32'(obs_done), 32'(edone));
        chk("busy_at_done", 32'(busy_done), 32'd1);
        chk("done_one_cycle", 32'(o_Done), 32'd0);
        chk("ready_after_done", 32'(o_Instr_Ready), 32'd1);
        chk("idle_not_busy", 32'(o_Busy), 32'd0);
        chk("alu_handshakes", 32'(n_hs), 32'd1);
        chk("alu_stable", 32'(stable), 32'd1);
        chk("alu_a", 32'(obs_a), 32'(ea));
        chk("alu_b", 32'(obs_b), 32'(eb));
        chk("alu_op", 32'(obs_op), 32'(t.op));
        chk("rf_cmd_count", 32'(obs_cmd.size()), 32'(ncmd));
        if (obs_cmd.size() == ncmd) begin
            chk("latchsel_cmd", 32'(obs_cmd[0]), 32'(COM_LATCHSEL));
            chk("latchsel_data", 32'(obs_data[0]), 32'(esel));
            if (ncmd > 1) begin
                chk("latchc_cmd", 32'(obs_cmd[1]), 32'(COM_LATCHC));
                chk("latchc_data", 32'(obs_data[1]), 32'(eres));
            end
            if (ncmd > 2) begin
                chk("latchf_cmd", 32'(obs_cmd[2]), 32'(COM_LATCHF));
                chk("latchf_data", 32'(obs_data[2]), 32'({8'h00, t.flags}));
            end
        end
        chk("error_flag", 32'(o_Error), 32'(ref_err));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    initial begin
        rf_mem = '{16'h0000, 16'h0005, 16'h0007, 16'h1234, 16'hFFFF, 16'h8000, 16'h0F0F, 16'h00FF};
        ref_mem = rf_mem;
        //            a  b  c op sf oka okb rdy res  flags spur   sel     A       B       res    wb done err
        vecs[0] = mkv(1, 2, 3, 0, 0, 1, 1, 0,  0, 'h00, 0, 'h0D1, 'h0005, 'h0007, 'h000C, 1,  7, 0);
        vecs[1] = mkv(1, 2, 3, 0, 1, 1, 1, 0,  0, 'hA5, 0, 'h0D1, 'h0005, 'h0007, 'h000C, 1,  8, 0);
        vecs[2] = mkv(4, 1, 6, 1, 0, 1, 1, 5,  2, 'h00, 1, 'h18C, 'hFFFF, 'h0005, 'hFFFA, 1, 14, 0);
        vecs[3] = mkv(5, 7, 0, 2, 1, 1, 1, 0, 11, 'h3C, 0, 'h03D, 'h8000, 'h00FF, 'h0000, 1, 19, 0);
        vecs[4] = mkv(2, 2, 7, 3, 1, 1, 1, 1, 12, 'h11, 0, 'h1D2, 'h0007, 'h0007, 'h0000, 0, 18, 1);
        vecs[5] = mkv(6, 3, 2, 4, 0, 0, 1, 2,  3, 'h00, 0, 'h09E, 'h0000, 'h000C, 'h000C, 1, 12, 1);

        repeat (2) @(negedge i_Clk);
        chk("rst_ready", 32'(o_Instr_Ready), 32'd0);
        chk("rst_busy", 32'(o_Busy), 32'd0);
        chk("rst_rf_valid", 32'(o_Rf_Valid), 32'd0);
        chk("rst_rf_cmd", 32'(o_Rf_Command), 32'(COM_NOP));
        chk("rst_rf_data", 32'(o_Rf_Data), 32'd0);
        chk("rst_alu_valid", 32'(o_Alu_Valid), 32'd0);
        chk("rst_done", 32'(o_Done), 32'd0);
        chk("rst_error", 32'(o_Error), 32'd0);
        chk("rst_alu_a", 32'(o_Alu_A), 32'd0);
        i_Reset_n = 1'b1;
        #1;
        chk("rel_ready", 32'(o_Instr_Ready), 32'd1);
        chk("rel_busy", 32'(o_Busy), 32'd0);
        chk("rel_rf_valid", 32'(o_Rf_Valid), 32'd0);
        chk("rel_error", 32'(o_Error), 32'd0);
        @(negedge i_Clk);

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].stim);
            chk("tbl_sel", 32'(obs_sel), 32'(vecs[i].exp_sel));
            chk("tbl_a", 32'(obs_a), 32'(vecs[i].exp_a));
            chk("tbl_b", 32'(obs_b), 32'(vecs[i].exp_b));
            chk("tbl_wb", 32'(obs_wb), 32'(vecs[i].exp_wb));
            if (vecs[i].exp_wb) chk("tbl_res", 32'(obs_res), 32'(vecs[i].exp_res));
            chk("tbl_done", 32'(obs_done), 32'(vecs[i].exp_done));
            chk("tbl_err", 32'(o_Error), 32'(vecs[i].exp_err));
        end

        // Abandon an instruction with reset while it waits for the ALU.
        i_Instr_Valid = 1'b1; i_IdxA = 3'd1; i_IdxB = 3'd2; i_IdxC = 3'd5; i_AluOp = 4'd0; i_SetFlags = 1'b1;
        i_Alu_Ready = 1'b1; i_Rf_Valid = 1'b1; i_Rf_Data = 16'h1111;
        @(negedge i_Clk);
        i_Instr_Valid = 1'b0;
        repeat (4) @(negedge i_Clk);
        chk("wait_busy", 32'(o_Busy), 32'd1);
        chk("wait_alu_valid", 32'(o_Alu_Valid), 32'd0);
        chk("wait_alu_a", 32'(o_Alu_A), 32'h1111);
        chk("wait_error", 32'(o_Error), 32'(ref_err));
        #2 i_Reset_n = 1'b0;
        #1;
        chk("async_busy", 32'(o_Busy), 32'd0);
        chk("async_ready", 32'(o_Instr_Ready), 32'd0);
        chk("async_error", 32'(o_Error), 32'd0);
        chk("async_alu_a", 32'(o_Alu_A), 32'd0);
        chk("async_alu_op", 32'(o_Alu_Op), 32'd0);
        chk("async_rf_valid", 32'(o_Rf_Valid), 32'd0);
        i_Alu_Ready = 1'b0; i_Rf_Valid = 1'b0;
        ref_err = 1'b0;
        @(negedge i_Clk);
        i_Reset_n = 1'b1;
        @(negedge i_Clk);
        chk("post_rst_ready", 32'(o_Instr_Ready), 32'd1);
        chk("post_rst_rf_valid", 32'(o_Rf_Valid), 32'd0);
        chk("post_rst_error", 32'(o_Error), 32'd0);
        r = vecs[0].stim;
        r.a = 3'd7; r.b = 3'd1; r.c = 3'd4; r.sf = 1'b1; r.flags = 8'h5A;
        run(r);

        for (int n = 0; n < 40; n++) begin
            r.a = 3'($urandom); r.b = 3'($urandom); r.c = 3'($urandom);
            r.op = 4'($urandom); r.sf = 1'($urandom); r.spur = 1'($urandom);
            r.ok_a = ($urandom_range(0, 9) != 0);
            r.ok_b = ($urandom_range(0, 9) != 0);
            r.rdy_dly = 8'($urandom_range(0, 4));
            k = int'($urandom_range(0, 15));
            if (k < 10)      r.res_dly = 8'($urandom_range(0, 3));
            else if (k < 13) r.res_dly = 8'($urandom_range(4, TO));
            else             r.res_dly = -8'sd1;
            r.flags = 8'($urandom);
            run(r);
        end

        for (int i = 0; i < 8; i++) chk("rf_contents", 32'(rf_mem[i]), 32'(ref_mem[i]));
        chk("f_contents", 32'(rf_f), 32'(ref_f));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_sequencer.md
Name: regfile_sequencer

Overview:
- Operand-fetch / write-back controller that sits directly upstream of the Argon register file and drives its command bus.
- For each accepted instruction it:
  - latches the rA/rB/rC index selection into the register file;
  - reads operands A and B;
  - hands both operands to the ALU over a valid/ready handshake;
  - waits for the ALU result;
  - writes the result to rC and, optionally, writes the ALU flags into F[7:0].
- Includes an ALU response timeout and a sticky error flag.

Parameters:
- WORD_WIDTH, 16, width of register-file data and ALU operands/result.
- INDEX_WIDTH, 3, width of one register index.
- CMD_WIDTH, 4, width of the register-file command field; encodings are COM_* from regfile_pkg.
- TIMEOUT, 64, maximum cycles spent waiting for an ALU result before aborting; must be ≥2.

Ports:
- i_Clk  input  1  clock, rising edge.
- i_Reset_n  input  1  asynchronous, active-low reset.
- i_Instr_Valid  input  1  instruction present.
- o_Instr_Ready  output  1  sequencer can accept an instruction.
- i_IdxA  input  INDEX_WIDTH  source A index.
- i_IdxB  input  INDEX_WIDTH  source B index.
- i_IdxC  input  INDEX_WIDTH  destination index.
- i_AluOp  input  4  ALU operation code, passed through.
- i_SetFlags  input  1  write ALU flags to F after write-back.
- o_Rf_Valid  output  1  register-file command strobe (drives bus i_valid).
- o_Rf_Command  output  CMD_WIDTH  register-file command.
- o_Rf_Data  output  WORD_WIDTH  register-file write data.
- i_Rf_Data  input  WORD_WIDTH  register-file read data.
- i_Rf_Valid  input  1  register-file read data valid.
- o_Alu_Valid  output  1  operands valid to ALU.
- i_Alu_Ready  input  1  ALU accepts operands.
- o_Alu_Op  output  4  registered copy of i_AluOp.
- o_Alu_A  output  WORD_WIDTH  operand A.
- o_Alu_B  output  WORD_WIDTH  operand B.
- i_Alu_Res_Valid  input  1  ALU result present (single-cycle pulse).
- i_Alu_Result  input  WORD_WIDTH  ALU result.
- i_Alu_Flags  input  8  ALU flags.
- o_Done  output  1  one-cycle pulse when an instruction retires.
- o_Error  output  1  sticky error (read not valid, or ALU timeout).
- o_Busy  output  1  high in every state except IDLE.

Behaviour:
- Reset:
  - Reset is asynchronous, active-low; i_Reset_n low forces IDLE immediately.
  - In reset, all outputs are 0, o_Rf_Command = COM_NOP (the package default, all zeros), and all internal registers are 0.
  - Reset mid-instruction abandons it; no further bus command is issued.
- Instruction accept:
  - o_Instr_Ready = (state == IDLE).
  - An instruction is accepted on a rising edge with i_Instr_Valid && o_Instr_Ready.
  - On accept, indices, op and set-flags are captured; inputs are don't-care afterwards.
- FSM states: IDLE, SEL, RDA, RDB, EXEC, WAIT, WB, FLG, DONE.
  - SEL: o_Rf_Valid = 1, command COM_LATCHSEL, o_Rf_Data = {zero pad, IdxC, IdxB, IdxA}, with IdxA in bits [INDEX_WIDTH-1:0]. Next state is RDA.
  - RDA: o_Rf_Valid = 0, command COM_READA. Capture i_Rf_Data into operand A at the edge. If i_Rf_Valid = 0, capture 0 and set o_Error. Next state is RDB.
  - RDB: same as RDA but with COM_READB and operand B. Next state is EXEC.
  - EXEC:
    - o_Alu_Valid = 1; operands and op are held stable.
    - Leave when i_Alu_Ready = 1; handshake completes on that edge.
    - The timeout counter is cleared on entry.
  - WAIT:
    - Counter increments each cycle.
    - On i_Alu_Res_Valid: capture result and flags, go to WB.
    - If the counter reaches TIMEOUT-1 without a result: set o_Error and go to DONE with no write-back.
    - A result arriving in the same cycle as the timeout wins.
    - A result pulse seen while in EXEC is ignored.
  - WB: o_Rf_Valid = 1, COM_LATCHC, o_Rf_Data = result. Issued even when IdxC = 0; the register file drops it. Next state is FLG if set-flags, else DONE.
  - FLG: o_Rf_Valid = 1, COM_LATCHF, o_Rf_Data = {zeros, flags[7:0]}. Next state is DONE.
  - DONE: o_Done = 1 for exactly one cycle. Next state is IDLE.
- Latency:
  - No new instruction is accepted before returning to IDLE, i.e. no back-to-back overlap.
  - Minimum: accept edge, then SEL, RDA, RDB, EXEC (ready high), WAIT (result same cycle), WB, DONE. o_Done is in the 7th cycle after accept, or the 8th with flags.
- Combinational outputs:
  - o_Rf_* and o_Alu_Valid are decoded combinationally from the state register only, so there is no input-to-output combinational path except none.
  - Outside the states above, o_Rf_Valid = 0 and o_Rf_Command = COM_NOP.
- o_Error:
  - Set as described above; cleared only by reset.
  - An error does not halt the FSM.

Test Plan:
- Reset release, then idle → after i_Reset_n rises, o_Instr_Ready = 1, o_Busy = 0, o_Rf_Valid = 0, o_Error = 0.
- IdxA=1, IdxB=2, IdxC=3, regfile r1=0x0005, r2=0x0007, ALU ready immediately, result 0x000C one cycle later, SetFlags=0:
  - LATCHSEL data = 0x00D1;
  - o_Alu_A = 5, o_Alu_B = 7;
  - LATCHC with 0x000C;
  - o_Done 7 cycles after accept.
- Same instruction with SetFlags=1 and flags 0xA5 → LATCHF with data 0x00A5 follows LATCHC; o_Done 8 cycles after accept.
- i_Alu_Ready held low for 5 cycles → o_Alu_Valid and operands stable throughout; exactly one handshake; no extra register-file commands issued.
- No result for TIMEOUT cycles → o_Error = 1, no LATCHC issued, o_Done pulses, o_Instr_Ready returns high.
- i_Reset_n asserted in WAIT → outputs go to 0 asynchronously; after release, a fresh instruction completes normally.
